exec_sched: RTL and testbench

EXEC_SCHED -- requirements
Module: exec_sched

---
 rtl/exec_sched.sv | 207 ++++++++++++++++++++
 tb/tb_exec_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sched.sv
// Execution sequencer: walks the src x dst address space for one job and
// issues source-read / partial-sum-read strobes, then drains the dst pipeline.
module exec_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        accum,
    input  logic        src_bank,
    input  logic        dst_bank,
    input  logic [12:0] ia_len,
    input  logic [12:0] oa_len,
    input  logic        stall,
    output logic        exec,
    output logic [12:0] ia,
    output logic        accr,
    output logic        outr,
    output logic [12:0] oa,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [2:0] DRAIN_LAST = 3'd4;

    state_t      state_reg, state_next;
    logic [11:0] i_reg, i_next;
    logic [11:0] o_reg, o_next;
    logic        accum_reg, accum_next;
    logic        src_bank_reg, src_bank_next;
    logic        dst_bank_reg, dst_bank_next;
    logic [12:0] ia_len_reg, ia_len_next;
    logic [12:0] oa_len_reg, oa_len_next;
    logic        last_reg, last_next;
    logic [2:0]  drain_cnt_reg, drain_cnt_next;

    logic        exec_reg, exec_next;
    logic [12:0] ia_reg, ia_next;
    logic        accr_reg, accr_next;
    logic        outr_reg, outr_next;
    logic [12:0] oa_reg, oa_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    // Beat selection: i/o point at the next beat to issue; in IDLE the beat
    // comes straight from the job inputs so the first exec costs no extra cycle.
    logic        issue_en;
    logic [11:0] beat_i, beat_o;
    logic        p_accum, p_src_bank, p_dst_bank;
    logic [12:0] p_ia_len, p_oa_len;
    logic        row_end, job_end;

    always_comb begin
        state_next     = state_reg;
        i_next         = i_reg;
        o_next         = o_reg;
        accum_next     = accum_reg;
        src_bank_next  = src_bank_reg;
        dst_bank_next  = dst_bank_reg;
        ia_len_next    = ia_len_reg;
        oa_len_next    = oa_len_reg;
        last_next      = last_reg;
        drain_cnt_next = drain_cnt_reg;
        exec_next      = 1'b0;
        accr_next      = 1'b0;
        outr_next      = 1'b0;
        ia_next        = ia_reg;
        oa_next        = oa_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        issue_en       = 1'b0;
        beat_i         = i_reg;
        beat_o         = o_reg;
        p_accum        = accum_reg;
        p_src_bank     = src_bank_reg;
        p_dst_bank     = dst_bank_reg;
        p_ia_len       = ia_len_reg;
        p_oa_len       = oa_len_reg;

        case (state_reg)
            IDLE: begin
                if (run) begin
                    accum_next    = accum;
                    src_bank_next = src_bank;
                    dst_bank_next = dst_bank;
                    ia_len_next   = ia_len;
                    oa_len_next   = oa_len;
                    p_accum       = accum;
                    p_src_bank    = src_bank;
                    p_dst_bank    = dst_bank;
                    p_ia_len      = ia_len;
                    p_oa_len      = oa_len;
                    beat_i        = 12'd0;
                    beat_o        = 12'd0;
                    i_next        = 12'd0;
                    o_next        = 12'd0;
                    last_next     = 1'b0;
                    if (ia_len == 13'd0 || oa_len == 13'd0) begin
                        state_next = FIN;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        state_next = ISSUE;
                        busy_next  = 1'b1;
                        issue_en   = ~stall;
                    end
                end
            end
            ISSUE: begin
                // last_reg means the final beat is on the outputs this cycle
                if (last_reg) begin
                    state_next     = DRAIN;
                    drain_cnt_next = 3'd0;
                end else begin
                    issue_en = ~stall;
                end
            end
            DRAIN: begin
                if (drain_cnt_reg == DRAIN_LAST) begin
                    state_next = FIN;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                end else begin
                    drain_cnt_next = drain_cnt_reg + 3'd1;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        row_end = ({1'b0, beat_i} == (p_ia_len - 13'd1));
        job_end = row_end && ({1'b0, beat_o} == (p_oa_len - 13'd1));

        if (issue_en) begin
            exec_next = 1'b1;
            ia_next   = {p_src_bank, beat_i};
            oa_next   = {p_dst_bank, beat_o};
            accr_next = (beat_i == 12'd0) && p_accum;
            outr_next = row_end;
            last_next = job_end;
            if (row_end) begin
                i_next = 12'd0;
                o_next = beat_o + 12'd1;
            end else begin
                i_next = beat_i + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            i_reg         <= 12'd0;
            o_reg         <= 12'd0;
            accum_reg     <= 1'b0;
            src_bank_reg  <= 1'b0;
            dst_bank_reg  <= 1'b0;
            ia_len_reg    <= 13'd0;
            oa_len_reg    <= 13'd0;
            last_reg      <= 1'b0;
            drain_cnt_reg <= 3'd0;
            exec_reg      <= 1'b0;
            ia_reg        <= 13'd0;
            accr_reg      <= 1'b0;
            outr_reg      <= 1'b0;
            oa_reg        <= 13'd0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            i_reg         <= i_next;
            o_reg         <= o_next;
            accum_reg     <= accum_next;
            src_bank_reg  <= src_bank_next;
            dst_bank_reg  <= dst_bank_next;
            ia_len_reg    <= ia_len_next;
            oa_len_reg    <= oa_len_next;
            last_reg      <= last_next;
            drain_cnt_reg <= drain_cnt_next;
            exec_reg      <= exec_next;
            ia_reg        <= ia_next;
            accr_reg      <= accr_next;
            outr_reg      <= outr_next;
            oa_reg        <= oa_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign exec = exec_reg;
    assign ia   = ia_reg;
    assign accr = accr_reg;
    assign outr = outr_reg;
    assign oa   = oa_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_exec_sched.sv
// Directed bench for exec_sched: beat sequences, stall, zero length, abort,
// ignored run, single-element rows and 4096-long counters.
module tb_exec_sched;

    logic        clk;
    logic        reset;
    logic        run;
    logic        accum;
    logic        src_bank;
    logic        dst_bank;
    logic [12:0] ia_len;
    logic [12:0] oa_len;
    logic        stall;
    logic        exec;
    logic [12:0] ia;
    logic        accr;
    logic        outr;
    logic [12:0] oa;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    exec_sched dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .accum    (accum),
        .src_bank (src_bank),
        .dst_bank (dst_bank),
        .ia_len   (ia_len),
        .oa_len   (oa_len),
        .stall    (stall),
        .exec     (exec),
        .ia       (ia),
        .accr     (accr),
        .outr     (outr),
        .oa       (oa),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // outputs are sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [12:0] e_ia, input logic [12:0] e_oa,
                            input logic e_accr, input logic e_outr);
        step();
        chk({tag, ".exec"}, {31'd0, exec}, 32'd1);
        chk({tag, ".ia"},   {19'd0, ia},   {19'd0, e_ia});
        chk({tag, ".oa"},   {19'd0, oa},   {19'd0, e_oa});
        chk({tag, ".accr"}, {31'd0, accr}, {31'd0, e_accr});
        chk({tag, ".outr"}, {31'd0, outr}, {31'd0, e_outr});
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic chk_quiet(input string tag, input logic e_busy, input logic e_done);
        step();
        chk({tag, ".exec"}, {31'd0, exec}, 32'd0);
        chk({tag, ".accr"}, {31'd0, accr}, 32'd0);
        chk({tag, ".outr"}, {31'd0, outr}, 32'd0);
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
    endtask

    // five drain cycles, one done cycle, then back to idle
    task automatic chk_tail(input string tag);
        for (int k = 0; k < 5; k++) chk_quiet({tag, ".drain"}, 1'b1, 1'b0);
        chk_quiet({tag, ".fin"}, 1'b0, 1'b1);
        chk_quiet({tag, ".idle"}, 1'b0, 1'b0);
    endtask

    task automatic start(input logic a, input logic sb, input logic db,
                         input logic [12:0] il, input logic [12:0] ol);
        accum = a; src_bank = sb; dst_bank = db; ia_len = il; oa_len = ol;
        run = 1'b1;
    endtask

    task automatic basic_seq(input string tag);
        chk_beat({tag, ".b1"}, 13'h0000, 13'h0000, 1'b0, 1'b0);
        run = 1'b0;
        chk_beat({tag, ".b2"}, 13'h0001, 13'h0000, 1'b0, 1'b0);
        chk_beat({tag, ".b3"}, 13'h0002, 13'h0000, 1'b0, 1'b1);
        chk_beat({tag, ".b4"}, 13'h0000, 13'h0001, 1'b0, 1'b0);
        chk_beat({tag, ".b5"}, 13'h0001, 13'h0001, 1'b0, 1'b0);
        chk_beat({tag, ".b6"}, 13'h0002, 13'h0001, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; accum = 1'b0; src_bank = 1'b0; dst_bank = 1'b0;
        ia_len = 13'd0; oa_len = 13'd0; stall = 1'b0;
        #1;
        chk("rst.exec", {31'd0, exec}, 32'd0);
        chk("rst.ia",   {19'd0, ia},   32'd0);
        chk("rst.oa",   {19'd0, oa},   32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        step(); step();
        reset = 1'b0;
        chk_quiet("rst.idle", 1'b0, 1'b0);

        // basic 3x2 job
        start(1'b0, 1'b0, 1'b0, 13'd3, 13'd2);
        basic_seq("basic");
        chk_tail("basic");

        // accumulate, bank 1
        start(1'b1, 1'b1, 1'b1, 13'd2, 13'd2);
        chk_beat("acc.b1", 13'h1000, 13'h1000, 1'b1, 1'b0);
        run = 1'b0;
        chk_beat("acc.b2", 13'h1001, 13'h1000, 1'b0, 1'b1);
        chk_beat("acc.b3", 13'h1000, 13'h1001, 1'b1, 1'b0);
        chk_beat("acc.b4", 13'h1001, 13'h1001, 1'b0, 1'b1);
        chk_tail("acc");

        // stall for 4 cycles after beat 2
        start(1'b0, 1'b0, 1'b0, 13'd3, 13'd2);
        chk_beat("stl.b1", 13'h0000, 13'h0000, 1'b0, 1'b0);
        run = 1'b0;
        chk_beat("stl.b2", 13'h0001, 13'h0000, 1'b0, 1'b0);
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_quiet("stl.hold", 1'b1, 1'b0);
            chk("stl.hold.ia", {19'd0, ia}, 32'h0001);
            chk("stl.hold.oa", {19'd0, oa}, 32'h0000);
        end
        stall = 1'b0;
        chk_beat("stl.b3", 13'h0002, 13'h0000, 1'b0, 1'b1);
        chk_beat("stl.b4", 13'h0000, 13'h0001, 1'b0, 1'b0);
        chk_beat("stl.b5", 13'h0001, 13'h0001, 1'b0, 1'b0);
        chk_beat("stl.b6", 13'h0002, 13'h0001, 1'b0, 1'b1);
        chk_tail("stl");

        // zero length
        start(1'b0, 1'b0, 1'b0, 13'd5, 13'd0);
        chk_quiet("zero.fin", 1'b0, 1'b1);
        run = 1'b0;
        chk_quiet("zero.idle", 1'b0, 1'b0);

        // reset abort during beat 3
        start(1'b0, 1'b0, 1'b0, 13'd3, 13'd2);
        chk_beat("abt.b1", 13'h0000, 13'h0000, 1'b0, 1'b0);
        run = 1'b0;
        chk_beat("abt.b2", 13'h0001, 13'h0000, 1'b0, 1'b0);
        chk_beat("abt.b3", 13'h0002, 13'h0000, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        chk("abt.exec", {31'd0, exec}, 32'd0);
        chk("abt.ia",   {19'd0, ia},   32'd0);
        chk("abt.oa",   {19'd0, oa},   32'd0);
        chk("abt.outr", {31'd0, outr}, 32'd0);
        chk("abt.busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) chk_quiet("abt.nodone", 1'b0, 1'b0);
        start(1'b0, 1'b0, 1'b0, 13'd3, 13'd2);
        basic_seq("abt.re");
        chk_tail("abt.re");

        // late parameter change and run pulse during drain
        start(1'b0, 1'b0, 1'b0, 13'd3, 13'd2);
        chk_beat("late.b1", 13'h0000, 13'h0000, 1'b0, 1'b0);
        run = 1'b0; ia_len = 13'd1; oa_len = 13'd7; accum = 1'b1; src_bank = 1'b1;
        chk_beat("late.b2", 13'h0001, 13'h0000, 1'b0, 1'b0);
        chk_beat("late.b3", 13'h0002, 13'h0000, 1'b0, 1'b1);
        chk_beat("late.b4", 13'h0000, 13'h0001, 1'b0, 1'b0);
        chk_beat("late.b5", 13'h0001, 13'h0001, 1'b0, 1'b0);
        chk_beat("late.b6", 13'h0002, 13'h0001, 1'b0, 1'b1);
        chk_quiet("late.d1", 1'b1, 1'b0);
        chk_quiet("late.d2", 1'b1, 1'b0);
        run = 1'b1;
        chk_quiet("late.d3", 1'b1, 1'b0);
        run = 1'b0;
        chk_quiet("late.d4", 1'b1, 1'b0);
        chk_quiet("late.d5", 1'b1, 1'b0);
        chk_quiet("late.fin", 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) chk_quiet("late.idle", 1'b0, 1'b0);

        // single-element rows, run together with stall
        start(1'b1, 1'b0, 1'b1, 13'd1, 13'd3);
        stall = 1'b1;
        chk_quiet("one.s1", 1'b1, 1'b0);
        run = 1'b0;
        chk_quiet("one.s2", 1'b1, 1'b0);
        stall = 1'b0;
        chk_beat("one.b1", 13'h0000, 13'h1000, 1'b1, 1'b1);
        chk_beat("one.b2", 13'h0000, 13'h1001, 1'b1, 1'b1);
        chk_beat("one.b3", 13'h0000, 13'h1002, 1'b1, 1'b1);
        chk_tail("one");

        // 4096-long input row
        start(1'b0, 1'b1, 1'b0, 13'd4096, 13'd1);
        chk_beat("bigi.b1", 13'h1000, 13'h0000, 1'b0, 1'b0);
        run = 1'b0;
        for (int k = 2; k < 4096; k++) step();
        chk_beat("bigi.last", 13'h1FFF, 13'h0000, 1'b0, 1'b1);
        chk_tail("bigi");

        // 4096 outputs of one element each
        start(1'b0, 1'b0, 1'b0, 13'd1, 13'd4096);
        chk_beat("bigo.b1", 13'h0000, 13'h0000, 1'b0, 1'b1);
        run = 1'b0;
        for (int k = 2; k < 4096; k++) step();
        chk_beat("bigo.last", 13'h0000, 13'h0FFF, 1'b0, 1'b1);
        chk_tail("bigo");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
